// File: rtl/enet_tx_pause_gen.sv
// 802.3x PAUSE frame generator for the MAC transmit side (tx_clk domain).
// Serialises a 60-byte PAUSE frame on request, acks it, and arbitrates against the data path.
module enet_tx_pause_gen #(
   parameter logic [47:0] PAUSE_DA   = 48'h0180C2000001,
   parameter logic [15:0] PAUSE_TYPE = 16'h8808,
   parameter logic [15:0] PAUSE_OPC  = 16'h0001,
   parameter int          FRAME_LEN  = 60
) (
   input  logic        tx_clk,
   input  logic        rst_n,
   input  logic        ether_en,
   input  logic [47:0] mac_addr,
   input  logic [15:0] pause_opd,
   input  logic        pause_send,
   input  logic        pause_send_zero,
   output logic        pause_mac_send,
   output logic        pause_mac_send_zero,
   input  logic        tx_stop,
   input  logic        data_busy,
   output logic        data_start_ok,
   output logic        tx_mac_stop,
   output logic        pf_valid,
   input  logic        pf_ready,
   output logic [7:0]  pf_data,
   output logic        pf_sof,
   output logic        pf_eof,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

   state_t      state;
   logic [5:0]  idx;
   logic        kind_nz;
   logic [15:0] time_q;
   logic [7:0]  byte_val;
   logic        req;

   assign req = pause_send | pause_send_zero;

   // Handshake: a byte transfers on a cycle where pf_valid & pf_ready; while
   // pf_valid is high and pf_ready low, pf_data/pf_sof/pf_eof hold their values.
   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         idx                 <= 6'd0;
         kind_nz             <= 1'b0;
         time_q              <= 16'h0000;
         pause_mac_send      <= 1'b0;
         pause_mac_send_zero <= 1'b0;
      end else begin
         pause_mac_send      <= 1'b0;
         pause_mac_send_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (req && ether_en && !data_busy) begin
                  state   <= SEND;
                  idx     <= 6'd0;
                  kind_nz <= pause_send;
                  time_q  <= pause_send ? pause_opd : 16'h0000;
               end
            end
            SEND: begin
               if (pf_ready) begin
                  if (idx == LAST_IDX) begin
                     state               <= ACK;
                     pause_mac_send      <= kind_nz;
                     pause_mac_send_zero <= !kind_nz;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Everything past the PAUSE time field is zero padding.
   always_comb begin
      byte_val = 8'h00;
      case (idx)
         6'd0:    byte_val = PAUSE_DA[47:40];
         6'd1:    byte_val = PAUSE_DA[39:32];
         6'd2:    byte_val = PAUSE_DA[31:24];
         6'd3:    byte_val = PAUSE_DA[23:16];
         6'd4:    byte_val = PAUSE_DA[15:8];
         6'd5:    byte_val = PAUSE_DA[7:0];
         6'd6:    byte_val = mac_addr[47:40];
         6'd7:    byte_val = mac_addr[39:32];
         6'd8:    byte_val = mac_addr[31:24];
         6'd9:    byte_val = mac_addr[23:16];
         6'd10:   byte_val = mac_addr[15:8];
         6'd11:   byte_val = mac_addr[7:0];
         6'd12:   byte_val = PAUSE_TYPE[15:8];
         6'd13:   byte_val = PAUSE_TYPE[7:0];
         6'd14:   byte_val = PAUSE_OPC[15:8];
         6'd15:   byte_val = PAUSE_OPC[7:0];
         6'd16:   byte_val = time_q[15:8];
         6'd17:   byte_val = time_q[7:0];
         default: byte_val = 8'h00;
      endcase
   end

   assign pf_valid      = (state == SEND);
   assign pf_data       = pf_valid ? byte_val : 8'h00;
   assign pf_sof        = pf_valid && (idx == 6'd0);
   assign pf_eof        = pf_valid && (idx == LAST_IDX);
   assign data_start_ok = (state == IDLE) && !req && ether_en && !tx_stop;
   assign tx_mac_stop   = tx_stop && !data_busy && (state == IDLE) && !req;
   assign state_dbg     = state;

endmodule

// File: tb/tb_enet_tx_pause_gen.sv
// Bench for enet_tx_pause_gen: randomized PAUSE frames checked against a byte-list model.
module tb_enet_tx_pause_gen;

   logic        tx_clk;
   logic        rst_n;
   logic        ether_en;
   logic [47:0] mac_addr;
   logic [15:0] pause_opd;
   logic        pause_send;
   logic        pause_send_zero;
   logic        pause_mac_send;
   logic        pause_mac_send_zero;
   logic        tx_stop;
   logic        data_busy;
   logic        data_start_ok;
   logic        tx_mac_stop;
   logic        pf_valid;
   logic        pf_ready;
   logic [7:0]  pf_data;
   logic        pf_sof;
   logic        pf_eof;
   logic [1:0]  state_dbg;

   enet_tx_pause_gen dut (
      .tx_clk(tx_clk), .rst_n(rst_n), .ether_en(ether_en), .mac_addr(mac_addr),
      .pause_opd(pause_opd), .pause_send(pause_send), .pause_send_zero(pause_send_zero),
      .pause_mac_send(pause_mac_send), .pause_mac_send_zero(pause_mac_send_zero),
      .tx_stop(tx_stop), .data_busy(data_busy), .data_start_ok(data_start_ok),
      .tx_mac_stop(tx_mac_stop), .pf_valid(pf_valid), .pf_ready(pf_ready),
      .pf_data(pf_data), .pf_sof(pf_sof), .pf_eof(pf_eof), .state_dbg(state_dbg)
   );

   // clock / reset
   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] got_data[$];
   logic       got_sof[$];
   logic       got_eof[$];
   int n_cmp = 0;
   int n_bad = 0;

   // per-frame observations filled by collect_frame
   int c_valid_cycles, c_ack_nz, c_ack_z, c_stall_viol, c_first_valid;
   int c_stop_bad, c_extra_valid, c_ack_at, c_last_beat_at;
   bit c_timeout;

   // Reference frame: DA, SA, EtherType, opcode, time, then pad to 60 bytes.
   function automatic void build_exp(input logic [47:0] mac, input logic [15:0] t);
      logic [47:0] da;
      logic [47:0] hdr;
      da  = 48'h0180C2000001;
      hdr = 48'h880800010000 | {32'h0, t};
      exp_q.delete();
      for (int i = 5; i >= 0; i--) exp_q.push_back(da[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(mac[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(hdr[i*8 +: 8]);
      while (exp_q.size() < 60) exp_q.push_back(8'h00);
   endfunction

   // Driver: runs the ready side until the ack, plus a few trailing cycles.
   // Inputs change and outputs are observed on the falling edge.
   task automatic collect_frame(input int ready_pct, input bit change_opd);
      bit prev_stall, acked, r;
      logic [7:0] sd;
      logic ss, se;
      int post;
      got_data.delete(); got_sof.delete(); got_eof.delete();
      c_valid_cycles = 0; c_ack_nz = 0; c_ack_z = 0; c_stall_viol = 0;
      c_first_valid = -1; c_stop_bad = 0; c_extra_valid = 0;
      c_ack_at = -1; c_last_beat_at = -1; c_timeout = 1'b1;
      prev_stall = 1'b0; acked = 1'b0; post = 0; sd = 8'h00; ss = 1'b0; se = 1'b0;
      for (int c = 0; c < 800; c++) begin
         @(negedge tx_clk);
         if (prev_stall && (pf_valid !== 1'b1 || pf_data !== sd || pf_sof !== ss || pf_eof !== se))
            c_stall_viol++;
         if ((pf_valid || pause_mac_send || pause_mac_send_zero) && tx_mac_stop) c_stop_bad++;
         if (acked && pf_valid) c_extra_valid++;
         if (pause_mac_send) c_ack_nz++;
         if (pause_mac_send_zero) c_ack_z++;
         if ((pause_mac_send || pause_mac_send_zero) && !acked) begin
            pause_send = 1'b0; pause_send_zero = 1'b0;
            acked = 1'b1; c_timeout = 1'b0; c_ack_at = c;
         end
         if (change_opd && c == 5) pause_opd = 16'($urandom);
         r = ($urandom_range(99) < ready_pct);
         pf_ready = r;
         prev_stall = 1'b0;
         if (pf_valid && !acked) begin
            c_valid_cycles++;
            if (c_first_valid < 0) c_first_valid = c;
            if (r) begin
               got_data.push_back(pf_data); got_sof.push_back(pf_sof); got_eof.push_back(pf_eof);
               c_last_beat_at = c;
            end else begin
               prev_stall = 1'b1; sd = pf_data; ss = pf_sof; se = pf_eof;
            end
         end
         if (acked) begin
            post++;
            if (post > 8) break;
         end
      end
      pf_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ether_en = 1'b1; mac_addr = 48'h0; pause_opd = 16'h0;
      pause_send = 1'b0; pause_send_zero = 1'b0; tx_stop = 1'b0; data_busy = 1'b0;
      pf_ready = 1'b0;
      repeat (3) @(negedge tx_clk);
      n_cmp++;
      if ({pf_valid, pf_data, pf_sof, pf_eof, pause_mac_send, pause_mac_send_zero, tx_mac_stop} !== 14'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {pf_valid, pf_data, pf_sof, pf_eof, pause_mac_send, pause_mac_send_zero, tx_mac_stop});
      end
      n_cmp++;
      if (data_start_ok !== 1'b1) begin
         n_bad++; $display("FAIL reset_data_start_ok: got %b expected 1", data_start_ok);
      end
      n_cmp++;
      if (state_dbg !== 2'd0) begin
         n_bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge tx_clk);
   endtask

   task automatic test_basic_frame();
      int byte_bad;
      mac_addr = 48'h001122334455; pause_opd = 16'h1234;
      build_exp(mac_addr, 16'h1234);
      pause_send = 1'b1;
      collect_frame(100, 1'b0);
      byte_bad = 0;
      for (int i = 0; i < 60 && i < got_data.size(); i++)
         if (got_data[i] !== exp_q[i] || got_sof[i] !== (i == 0) || got_eof[i] !== (i == 59)) byte_bad++;
      n_cmp++;
      if (got_data.size() != 60 || c_valid_cycles != 60) begin
         n_bad++; $display("FAIL basic_beats: got %0d beats in %0d cycles expected 60/60", got_data.size(), c_valid_cycles);
      end
      n_cmp++;
      if (byte_bad != 0) begin
         n_bad++; $display("FAIL basic_bytes: got %0d bad bytes expected 0", byte_bad);
      end
      n_cmp++;
      if (c_timeout || c_ack_nz != 1 || c_ack_z != 0 || c_ack_at != c_last_beat_at + 1) begin
         n_bad++; $display("FAIL basic_ack: got nz=%0d z=%0d at %0d (last beat %0d) expected 1/0 next cycle",
                           c_ack_nz, c_ack_z, c_ack_at, c_last_beat_at);
      end
      n_cmp++;
      if (c_extra_valid != 0) begin
         n_bad++; $display("FAIL basic_no_second: got %0d valid cycles after ack expected 0", c_extra_valid);
      end
   endtask

   task automatic test_zero_pause();
      int byte_bad;
      mac_addr = 48'hA1B2C3D4E5F6; pause_opd = 16'hBEEF;
      build_exp(mac_addr, 16'h0000);
      pause_send_zero = 1'b1;
      collect_frame(100, 1'b0);
      byte_bad = 0;
      for (int i = 0; i < 60 && i < got_data.size(); i++)
         if (got_data[i] !== exp_q[i]) byte_bad++;
      n_cmp++;
      if (got_data.size() != 60 || byte_bad != 0 || got_data[16] !== 8'h00 || got_data[17] !== 8'h00) begin
         n_bad++; $display("FAIL zero_bytes: got %0d beats %0d bad expected 60/0", got_data.size(), byte_bad);
      end
      n_cmp++;
      if (c_timeout || c_ack_z != 1 || c_ack_nz != 0) begin
         n_bad++; $display("FAIL zero_ack: got nz=%0d z=%0d expected 0/1", c_ack_nz, c_ack_z);
      end
   endtask

   task automatic test_backpressure();
      int byte_bad;
      mac_addr = 48'h0A0B0C0D0E0F; pause_opd = 16'h00FF;
      build_exp(mac_addr, 16'h00FF);
      pause_send = 1'b1;
      collect_frame(50, 1'b0);
      byte_bad = 0;
      for (int i = 0; i < 60 && i < got_data.size(); i++)
         if (got_data[i] !== exp_q[i] || got_sof[i] !== (i == 0) || got_eof[i] !== (i == 59)) byte_bad++;
      n_cmp++;
      if (got_data.size() != 60 || byte_bad != 0) begin
         n_bad++; $display("FAIL bp_bytes: got %0d beats %0d bad expected 60/0", got_data.size(), byte_bad);
      end
      n_cmp++;
      if (c_stall_viol != 0) begin
         n_bad++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", c_stall_viol);
      end
      n_cmp++;
      if (c_timeout || c_ack_nz != 1 || c_ack_z != 0) begin
         n_bad++; $display("FAIL bp_ack: got nz=%0d z=%0d expected 1/0", c_ack_nz, c_ack_z);
      end
   endtask

   task automatic test_data_busy();
      int early;
      mac_addr = 48'h123456789ABC; pause_opd = 16'h4321;
      build_exp(mac_addr, 16'h4321);
      data_busy = 1'b1;
      pause_send = 1'b1;
      early = 0;
      repeat (5) begin
         @(negedge tx_clk);
         if (pf_valid !== 1'b0 || pf_sof !== 1'b0 || data_start_ok !== 1'b0) early++;
      end
      n_cmp++;
      if (early != 0) begin
         n_bad++; $display("FAIL busy_block: got %0d cycles with valid/start_ok expected 0", early);
      end
      data_busy = 1'b0;
      collect_frame(100, 1'b0);
      n_cmp++;
      if (c_first_valid != 0 || got_sof.size() == 0 || got_sof[0] !== 1'b1) begin
         n_bad++; $display("FAIL busy_sof_next: got first valid at %0d expected 0", c_first_valid);
      end
      n_cmp++;
      if (got_data.size() != 60 || c_ack_nz != 1) begin
         n_bad++; $display("FAIL busy_frame: got %0d beats ack %0d expected 60/1", got_data.size(), c_ack_nz);
      end
   endtask

   task automatic test_tx_stop();
      tx_stop = 1'b1;
      @(negedge tx_clk);
      n_cmp++;
      if (tx_mac_stop !== 1'b1 || data_start_ok !== 1'b0) begin
         n_bad++; $display("FAIL stop_idle: got mac_stop=%b start_ok=%b expected 1/0", tx_mac_stop, data_start_ok);
      end
      mac_addr = 48'h665544332211; pause_opd = 16'h0F0F;
      pause_send = 1'b1;
      #1;
      n_cmp++;
      if (tx_mac_stop !== 1'b0) begin
         n_bad++; $display("FAIL stop_req_pending: got %b expected 0", tx_mac_stop);
      end
      collect_frame(80, 1'b0);
      n_cmp++;
      if (got_data.size() != 60 || c_ack_nz != 1 || c_stop_bad != 0) begin
         n_bad++; $display("FAIL stop_frame: got %0d beats ack %0d stop-high %0d expected 60/1/0",
                           got_data.size(), c_ack_nz, c_stop_bad);
      end
      n_cmp++;
      if (tx_mac_stop !== 1'b1) begin
         n_bad++; $display("FAIL stop_return: got %b expected 1", tx_mac_stop);
      end
      tx_stop = 1'b0;
      @(negedge tx_clk);
   endtask

   task automatic test_reset_midframe();
      int cnt, stray;
      logic [15:0] opd_a;
      mac_addr = 48'hDEADBEEF0001; pause_opd = 16'h5A5A;
      pause_send = 1'b1; pf_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge tx_clk);
         if (pf_valid) begin
            if (cnt == 20) break;
            cnt++;
         end
      end
      pause_send = 1'b0; pf_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pf_valid, pf_data, pf_sof, pf_eof, pause_mac_send, pause_mac_send_zero, tx_mac_stop} !== 14'h0 || cnt != 20) begin
         n_bad++; $display("FAIL midreset_outputs: got %h (beats %0d) expected 0 (20)",
                           {pf_valid, pf_data, pf_sof, pf_eof, pause_mac_send, pause_mac_send_zero, tx_mac_stop}, cnt);
      end
      repeat (2) @(negedge tx_clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge tx_clk);
         if (pf_valid || pause_mac_send || pause_mac_send_zero) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++; $display("FAIL midreset_no_ack: got %0d active cycles expected 0", stray);
      end
      opd_a = 16'($urandom);
      pause_opd = opd_a;
      build_exp(mac_addr, opd_a);
      pause_send = 1'b1;
      collect_frame(70, 1'b1);
      n_cmp++;
      if (got_data.size() != 60 || got_data[16] !== opd_a[15:8] || got_data[17] !== opd_a[7:0]) begin
         n_bad++; $display("FAIL midreset_latched_time: got %0d beats expected time %h", got_data.size(), opd_a);
      end
   endtask

   task automatic test_random_frames();
      int byte_bad, want_nz;
      logic [15:0] t;
      bit zero;
      for (int f = 0; f < 8; f++) begin
         mac_addr = {16'($urandom), 32'($urandom)};
         pause_opd = 16'($urandom);
         zero = ($urandom_range(1) == 1);
         t = zero ? 16'h0000 : pause_opd;
         build_exp(mac_addr, t);
         if (zero) pause_send_zero = 1'b1;
         else pause_send = 1'b1;
         if (!zero && $urandom_range(1) == 1) pause_send_zero = 1'b1;
         want_nz = zero ? 0 : 1;
         collect_frame($urandom_range(100, 30), 1'b0);
         byte_bad = 0;
         for (int i = 0; i < 60 && i < got_data.size(); i++)
            if (got_data[i] !== exp_q[i] || got_sof[i] !== (i == 0) || got_eof[i] !== (i == 59)) byte_bad++;
         n_cmp++;
         if (got_data.size() != 60 || byte_bad != 0 || c_stall_viol != 0) begin
            n_bad++; $display("FAIL rand_frame%0d: got %0d beats %0d bad %0d unstable expected 60/0/0",
                              f, got_data.size(), byte_bad, c_stall_viol);
         end
         n_cmp++;
         if (c_timeout || c_ack_nz != want_nz || c_ack_z != 1 - want_nz || c_extra_valid != 0) begin
            n_bad++; $display("FAIL rand_ack%0d: got nz=%0d z=%0d extra=%0d expected %0d/%0d/0",
                              f, c_ack_nz, c_ack_z, c_extra_valid, want_nz, 1 - want_nz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_zero_pause();
      test_backpressure();
      test_data_busy();
      test_tx_stop();
      test_reset_midframe();
      test_random_frames();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
